// File: rtl/srt_otf_conv.sv
// Radix-4 SRT on-the-fly quotient converter: Q/QM accumulation, remainder-sign correction, valid/ready output.
// Optional abort input enabled by defining SRT_OTF_ABORT_EN.
module srt_otf_conv #(
   parameter  int N_DIGITS = 16,
   localparam int QW       = 2 * N_DIGITS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    q_digit,
   input  logic          corr_valid,
   output logic          corr_ready,
   input  logic          rem_neg,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] quotient,
`ifdef SRT_OTF_ABORT_EN
   input  logic          abort,
`endif
   output logic          busy,
   output logic          err
);

   localparam int CW = $clog2(N_DIGITS + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, CORRECT, DONE} state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] q_q, q_d, qm_q, qm_d, quot_q, quot_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          abort_w;

`ifdef SRT_OTF_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Digit decode: which register each new value is shifted from, and the appended 2-bit tail.
   logic          q_from_qm, qm_from_q, illegal;
   logic [1:0]    q_tail, qm_tail;
   logic [QW-1:0] q_base, qm_base;

   always_comb begin
      q_from_qm = 1'b0;
      qm_from_q = 1'b0;
      q_tail    = 2'd0;
      qm_tail   = 2'd3;
      illegal   = 1'b0;
      case (q_digit)
         3'b000: ;
         3'b001: begin qm_from_q = 1'b1; q_tail = 2'd1; qm_tail = 2'd0; end
         3'b010: begin qm_from_q = 1'b1; q_tail = 2'd2; qm_tail = 2'd1; end
         3'b111: begin q_from_qm = 1'b1; q_tail = 2'd3; qm_tail = 2'd2; end
         3'b110: begin q_from_qm = 1'b1; q_tail = 2'd2; qm_tail = 2'd1; end
         default: illegal = 1'b1;
      endcase
   end

   assign q_base  = q_from_qm ? qm_q : q_q;
   assign qm_base = qm_from_q ? q_q  : qm_q;

   assign in_ready   = (state_q == COLLECT) && !abort_w;
   assign corr_ready = (state_q == CORRECT) && !abort_w;
   assign out_valid  = (state_q == DONE)    && !abort_w;
   assign busy       = (state_q != IDLE);
   assign quotient   = quot_q;
   assign err        = err_q;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      qm_d    = qm_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               q_d     = '0;
               qm_d    = '1;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid && in_ready) begin
               q_d   = {q_base[QW-3:0], q_tail};
               qm_d  = {qm_base[QW-3:0], qm_tail};
               cnt_d = cnt_q + CW'(1);
               err_d = err_q | illegal;
               if (cnt_q == CW'(N_DIGITS - 1)) state_d = CORRECT;
            end
         end
         CORRECT: begin
            if (corr_valid && corr_ready) begin
               quot_d  = rem_neg ? qm_q : q_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort_w) begin
         state_d = IDLE;
         q_d     = '0;
         qm_d    = '1;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         qm_q    <= '1;
         cnt_q   <= '0;
         quot_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         qm_q    <= qm_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_srt_otf_conv.sv
// Scoreboard bench for srt_otf_conv (N_DIGITS=4): quotient predicted as sum of digits * 4^k minus rem_neg, mod 2^QW.
module tb_srt_otf_conv;

   localparam int ND = 4;
   localparam int QW = 2 * ND;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, corr_valid, rem_neg, out_ready;
   logic [2:0]    q_digit;
   logic          in_ready, corr_ready, out_valid, busy, err;
   logic [QW-1:0] quotient;
`ifdef SRT_OTF_ABORT_EN
   logic          abort = 1'b0;
`endif

   typedef struct {
      logic [QW-1:0] q;
      logic          e;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rmode  = 0;

   srt_otf_conv #(.N_DIGITS(ND)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .q_digit    (q_digit),
      .corr_valid (corr_valid),
      .corr_ready (corr_ready),
      .rem_neg    (rem_neg),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
`ifdef SRT_OTF_ABORT_EN
      .abort      (abort),
`endif
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int dval(input logic [2:0] c);
      case (c)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b111:  return -1;
         3'b110:  return -2;
         default: return 0;
      endcase
   endfunction

   function automatic bit legal(input logic [2:0] c);
      return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b111) || (c == 3'b110);
   endfunction

   function automatic logic [QW-1:0] model(input logic [2:0] c[ND], input logic rn, output logic e);
      int v;
      v = 0;
      e = 1'b0;
      for (int i = 0; i < ND; i++) begin
         v = v * 4 + dval(c[i]);
         if (!legal(c[i])) e = 1'b1;
      end
      v = v - int'(rn);
      return v[QW-1:0];
   endfunction

   // Monitor: compares whatever the DUT presents against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst !== 1'b1 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check("quotient", 32'(quotient), 32'(sb[0].q));
            if (out_ready) begin
               check("err_at_output", 32'(err), 32'(sb[0].e));
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rmode == 0) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic run_conv(input logic [2:0] c[ND], input logic rn, input bit toggle,
                           input bit stray, input bit wait_done);
      exp_t x;
      int   idx, cyc;
      logic e;
      @(posedge clk); #1;
      start = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
         in_valid = 1'b1;
         q_digit  = 3'b010;
      end
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("err_clear_on_start", 32'(err), 32'd0);
      idx = 0;
      cyc = 0;
      while (idx < ND && cyc < 200) begin
         in_valid = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
         q_digit  = c[idx];
         start    = stray && (cyc == 2);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("digits_consumed", 32'(idx), 32'(ND));
      check("corr_ready_latency", 32'(corr_ready), 32'd1);
      check("in_ready_after_last", 32'(in_ready), 32'd0);
      x.q = model(c, rn, e);
      x.e = e;
      sb.push_back(x);
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
      corr_valid = 1'b1;
      rem_neg    = rn;
      @(posedge clk); #1;
      corr_valid = 1'b0;
      rem_neg    = 1'($urandom_range(0, 1));
      check("out_valid_latency", 32'(out_valid), 32'd1);
      check("corr_ready_in_done", 32'(corr_ready), 32'd0);
      if (wait_done) begin
         cyc = 0;
         while (busy && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
         end
         check("idle_after_out", 32'(busy), 32'd0);
      end
   endtask

   logic [2:0] c[ND];
   logic [2:0] legal_codes[5];
   int         cyc;

   initial begin
      legal_codes = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b110};
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; corr_valid = 1'b0;
      rem_neg = 1'b0; out_ready = 1'b0; q_digit = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_handshakes", {29'd0, in_ready, corr_ready, out_valid}, 32'd0);
      rst = 1'b0;

      c = '{3'b001, 3'b110, 3'b000, 3'b010};
      run_conv(c, 1'b0, 1'b0, 1'b0, 1'b1);
      run_conv(c, 1'b1, 1'b0, 1'b0, 1'b1);

      // Output stall: quotient must hold while out_ready stays low.
      rmode = 1;
      out_ready = 1'b0;
      c = '{3'b010, 3'b010, 3'b010, 3'b010};
      run_conv(c, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) begin
         @(posedge clk); #1;
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_quotient", 32'(quotient), 32'hAA);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_ready_busy", 32'(busy), 32'd0);
      check("idle_after_ready_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      rmode = 0;

      c = '{3'b101, 3'b001, 3'b001, 3'b001};
      run_conv(c, 1'b0, 1'b0, 1'b0, 1'b1);
      check("err_sticky_idle", 32'(err), 32'd1);

      // Reset after two accepted digits.
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      q_digit = 3'b001;
      repeat (2) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      c = '{3'b000, 3'b000, 3'b000, 3'b111};
      run_conv(c, 1'b0, 1'b0, 1'b0, 1'b1);

      c = '{3'b111, 3'b010, 3'b110, 3'b001};
      run_conv(c, 1'b1, 1'b1, 1'b1, 1'b1);

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < ND; i++) begin
            if ($urandom_range(0, 9) == 0) c[i] = 3'($urandom_range(3, 5));
            else c[i] = legal_codes[$urandom_range(0, 4)];
         end
         run_conv(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1);
      end

`ifdef SRT_OTF_ABORT_EN
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      q_digit = 3'b001;
      repeat (ND) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("abort_in_correct", 32'(corr_ready), 32'd1);
      abort = 1'b1;
      corr_valid = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      repeat (10) begin
         @(posedge clk); #1;
         check("abort_no_out_valid", 32'(out_valid), 32'd0);
      end
      corr_valid = 1'b0;
`endif

      cyc = 0;
      while (sb.size() != 0 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
